// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types and defaults for the UART command assembler.
package uart_cmd_pkg;
    typedef enum logic {WAIT_HI = 1'b0, WAIT_LO = 1'b1} asm_state_t;
    localparam int CMD_W         = 16;
    localparam int TO_CYCLES_DEF = 78125;
    localparam int TO_W_DEF      = 17;
endpackage

// File: rtl/uart_cmd_assembler_timer.sv
// Inter-byte timer: up-counter with sync clear and enable; expired marks the last in-window count.
module cmd_timer
    import uart_cmd_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter int TO_W      = TO_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TO_W-1:0] LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = (count == LAST);
endmodule

// File: rtl/uart_cmd_assembler.sv
// Pairs receiver bytes into 16-bit commands {high, low}; drops a stranded high byte on timeout.
// state   | meaning
// WAIT_HI | idle, next accepted byte is the high byte
// WAIT_LO | high byte held, waiting for low byte or timer expiry
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter int TO_W      = TO_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_rdy,
    output logic             clr_rx_rdy,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    output logic             overrun,
    output logic             timeout
);
    asm_state_t state;
    logic [7:0] hi_reg;
    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;
    logic       complete;

    assign clr_rx_rdy = rx_rdy & rst_n;
    assign timer_clr  = (state == WAIT_HI) && rx_rdy;
    assign timer_en   = (state == WAIT_LO) && !rx_rdy;
    assign complete   = (state == WAIT_LO) && rx_rdy;

    cmd_timer #(
        .TO_CYCLES(TO_CYCLES),
        .TO_W     (TO_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= WAIT_HI;
            hi_reg  <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                WAIT_HI: begin
                    if (rx_rdy) begin
                        hi_reg <= rx_data;
                        state  <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // An arriving byte beats a simultaneous expiry.
                    if (rx_rdy) begin
                        cmd   <= {hi_reg, rx_data};
                        state <= WAIT_HI;
                    end else if (timer_expired) begin
                        timeout <= 1'b1;
                        state   <= WAIT_HI;
                    end
                end
                default: state <= WAIT_HI;
            endcase

            if (complete) begin
                cmd_rdy <= 1'b1;
                if (clr_cmd_rdy) begin
                    overrun <= 1'b0;
                end else if (cmd_rdy) begin
                    overrun <= 1'b1;
                end
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler with a short timeout for fast runs.
module tb_uart_cmd_assembler;
    localparam int T  = 64;
    localparam int TW = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        overrun;
    logic        timeout;

    uart_cmd_assembler #(.TO_CYCLES(T), .TO_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_to;
        logic [15:0] cmd;
        int          cyc;
        bit          ov;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          clr_count = 0;
    int          bytes_sent = 0;
    logic [15:0] prev_cmd = '0;
    logic        prev_rdy = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_rx_rdy) clr_count <= clr_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per presented event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (timeout) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_timeout: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("timeout_kind", 32'(e.is_to), 32'd1);
                    chk("timeout_cycle", cyc, e.cyc);
                end
            end
            if ((cmd_rdy && !prev_rdy) || (cmd !== prev_cmd)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got %0h expected none (cycle %0d)", cmd, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("cmd_kind", 32'(e.is_to), 32'd0);
                    chk("cmd_value", 32'(cmd), 32'(e.cmd));
                    chk("cmd_cycle", cyc, e.cyc);
                    chk("cmd_rdy", 32'(cmd_rdy), 32'd1);
                    chk("overrun", 32'(overrun), 32'(e.ov));
                end
            end
        end
        prev_cmd = cmd;
        prev_rdy = cmd_rdy;
    end

    task automatic send_byte(input logic [7:0] b, input bit clr_same, output int acc);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        if (clr_same) clr_cmd_rdy = 1'b1;
        #1;
        chk("clr_rx_rdy_high", 32'(clr_rx_rdy), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        bytes_sent++;
    endtask

    task automatic send_cmd(input logic [15:0] c, input bit ov, input bit clr_same);
        int a;
        exp_t e;
        send_byte(c[15:8], 1'b0, a);
        send_byte(c[7:0], clr_same, a);
        e.is_to = 1'b0; e.cmd = c; e.cyc = a; e.ov = ov;
        sb.push_back(e);
    endtask

    task automatic pulse_clr(input logic [15:0] held);
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        chk("clr_cmd_rdy_rdy", 32'(cmd_rdy), 32'd0);
        chk("clr_cmd_rdy_ovr", 32'(overrun), 32'd0);
        chk("clr_cmd_rdy_held", 32'(cmd), 32'(held));
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a2;
        exp_t e;
        rst_n = 1'b0; rx_data = '0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd", 32'(cmd), 32'd0);
        chk("reset_flags", {29'd0, cmd_rdy, overrun, timeout}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two bytes 40 cycles apart.
        begin
            int c0;
            c0 = clr_count;
            send_byte(8'hA5, 1'b0, a);
            wait_until(a + 39);
            send_byte(8'h3C, 1'b0, a2);
            e.is_to = 1'b0; e.cmd = 16'hA53C; e.cyc = a2; e.ov = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            chk("clr_rx_rdy_pulses", clr_count - c0, 32'd2);
        end
        pulse_clr(16'hA53C);

        // Stranded high byte times out, then a fresh command.
        send_byte(8'h12, 1'b0, a);
        e.is_to = 1'b1; e.cmd = '0; e.cyc = a + T; e.ov = 1'b0;
        sb.push_back(e);
        wait_until(a + T + 3);
        send_cmd(16'h3456, 1'b0, 1'b0);
        pulse_clr(16'h3456);

        // Overrun from two unconsumed commands (back-to-back bytes).
        send_cmd(16'h0102, 1'b0, 1'b0);
        send_cmd(16'h0304, 1'b1, 1'b0);
        @(negedge clk);
        chk("overrun_rdy", 32'(cmd_rdy), 32'd1);
        chk("overrun_set", 32'(overrun), 32'd1);
        pulse_clr(16'h0304);

        // Acknowledge coincides with second completion.
        send_cmd(16'h0506, 1'b0, 1'b0);
        send_cmd(16'h0708, 1'b0, 1'b1);
        @(negedge clk);
        chk("ack_collide_rdy", 32'(cmd_rdy), 32'd1);
        chk("ack_collide_ovr", 32'(overrun), 32'd0);
        pulse_clr(16'h0708);

        // Low byte lands in the expiry cycle.
        send_byte(8'h0A, 1'b0, a);
        wait_until(a + T - 1);
        send_byte(8'h0B, 1'b0, a2);
        chk("expiry_accept_cycle", a2, a + T);
        e.is_to = 1'b0; e.cmd = 16'h0A0B; e.cyc = a2; e.ov = 1'b0;
        sb.push_back(e);
        wait_until(a2 + T + 5);

        // Reset mid-command with a byte pending through reset.
        send_byte(8'h99, 1'b0, a);
        @(negedge clk);
        rst_n = 1'b0;
        rx_data = 8'h77;
        rx_rdy = 1'b1;
        #1;
        chk("clr_rx_rdy_in_reset", 32'(clr_rx_rdy), 32'd0);
        @(posedge clk); #1;
        chk("mid_reset_cmd", 32'(cmd), 32'd0);
        chk("mid_reset_flags", {29'd0, cmd_rdy, overrun, timeout}, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        bytes_sent++;
        send_byte(8'h88, 1'b0, a2);
        e.is_to = 1'b0; e.cmd = 16'h7788; e.cyc = a2; e.ov = 1'b0;
        sb.push_back(e);

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
            @(posedge clk); #1;
            chk("scoreboard_drained", sb.size(), 32'd0);
        end
        chk("clr_rx_rdy_total", clr_count, bytes_sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
